// File: rtl/hazard_stall_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl_if
//
// Bundle between the hazard request sources (load-use detector, EX branch
// unit, data memory) and the stall/flush controller.
//
// Request side (driven by the pipeline, read by the controller):
//   load_use_hazard  load-use hazard seen in ID this cycle
//   branch_taken     taken branch/jump resolved in EX this cycle
//   dmem_busy        data memory not ready, pipeline must freeze
//
// Control side (driven by the controller, read by the pipeline registers):
//   pc_write         PC write enable
//   if_id_write      IF/ID write enable
//   if_id_flush      IF/ID clear to NOP
//   id_ex_write      ID/EX write enable
//   id_ex_flush      ID/EX clear to bubble
//   ex_mem_write     EX/MEM write enable
//
// Modports:
//   master  the pipeline side (drives requests, consumes controls)
//   slave   the controller side (consumes requests, drives controls)
// ----------------------------------------------------------------------------
interface hazard_stall_ctrl_if;

    logic load_use_hazard;
    logic branch_taken;
    logic dmem_busy;

    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;

    modport master (
        output load_use_hazard,
        output branch_taken,
        output dmem_busy,
        input  pc_write,
        input  if_id_write,
        input  if_id_flush,
        input  id_ex_write,
        input  id_ex_flush,
        input  ex_mem_write
    );

    modport slave (
        input  load_use_hazard,
        input  branch_taken,
        input  dmem_busy,
        output pc_write,
        output if_id_write,
        output if_id_flush,
        output id_ex_write,
        output id_ex_flush,
        output ex_mem_write
    );

endinterface

// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Turns the pipeline's hazard requests into per-stage write-enable and flush
// controls for PC, IF/ID, ID/EX and EX/MEM. Controls are combinational from
// the current state and the current requests, so a stall or flush takes
// effect in the same cycle the request is raised.
//
// Per-cycle priority: dmem_busy > branch_taken > load_use_hazard.
//
//   dmem_busy     freeze every stage, no flush; state is held
//   branch_taken  flush IF/ID and ID/EX for FLUSH_CYCLES cycles
//   load-use      one bubble into ID/EX while PC and IF/ID hold
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   pipe          hazard_stall_ctrl_if.slave (requests in, stage controls out)
//   stall_cycles  saturating count of cycles with pc_write=0 (out of reset)
//   flush_events  saturating count of accepted taken branches
//   mem_timeout   sticky; dmem_busy held for MEM_TIMEOUT consecutive cycles
//
// Parameters:
//   FLUSH_CYCLES  cycles IF/ID and ID/EX are flushed per taken branch (1..15)
//   MEM_TIMEOUT   consecutive busy cycles that raise mem_timeout (>= 1)
//   CNT_W         width of the saturating performance counters
// ----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 64,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_stall_ctrl_if.slave   pipe,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_events,
    output logic                 mem_timeout
);

    // ------------------------------------------------------------------------
    // Local types and constants
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    // Wide enough to hold MEM_TIMEOUT itself, where the wait counter parks.
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [3:0]        FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX     = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST    = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX      = {CNT_W{1'b1}};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              state;
    state_t              next_state;
    logic [3:0]          flush_cnt;
    logic [3:0]          next_flush_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                branch_accept;

    // Stage controls, computed locally and then driven onto the interface.
    logic pc_en;
    logic if_id_en;
    logic if_id_clr;
    logic id_ex_en;
    logic id_ex_clr;
    logic ex_mem_en;

    // ------------------------------------------------------------------------
    // Control decode and next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the branches below can leave one unassigned and infer a latch.
        pc_en          = 1'b1;
        if_id_en       = 1'b1;
        if_id_clr      = 1'b0;
        id_ex_en       = 1'b1;
        id_ex_clr      = 1'b0;
        ex_mem_en      = 1'b1;
        next_state     = state;
        next_flush_cnt = flush_cnt;
        branch_accept  = 1'b0;

        if (!rst_n) begin
            // Hold every stage and clear IF/ID and ID/EX to NOP while in reset.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            if_id_clr = 1'b1;
            id_ex_clr = 1'b1;
        end else if (pipe.dmem_busy) begin
            // Full freeze: nothing moves and nothing is cleared, so the
            // branch and load-use requests are simply ignored this cycle.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (pipe.branch_taken) begin
            // Wrong-path instructions in IF/ID and ID/EX are discarded while
            // the branch target is fetched. A branch during FLUSH restarts
            // the sequence from the top.
            if_id_clr     = 1'b1;
            id_ex_clr     = 1'b1;
            branch_accept = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                next_state     = FLUSH;
                next_flush_cnt = FLUSH_RELOAD;
            end else begin
                next_state     = RUN;
                next_flush_cnt = 4'd0;
            end
        end else begin
            unique case (state)
                FLUSH: begin
                    // Still on the wrong path: keep clearing, and ignore
                    // load-use requests raised by squashed instructions.
                    if_id_clr      = 1'b1;
                    id_ex_clr      = 1'b1;
                    next_flush_cnt = flush_cnt - 4'd1;
                    if (flush_cnt <= 4'd1) begin
                        next_state = RUN;
                    end
                end
                LU_STALL: begin
                    // The bubble is already in ID/EX; the load has moved on,
                    // so a still-asserted request refers to the same load.
                    next_state = RUN;
                end
                default: begin
                    if (pipe.load_use_hazard) begin
                        pc_en      = 1'b0;
                        if_id_en   = 1'b0;
                        id_ex_clr  = 1'b1;
                        next_state = LU_STALL;
                    end
                end
            endcase
        end
    end

    assign pipe.pc_write     = pc_en;
    assign pipe.if_id_write  = if_id_en;
    assign pipe.if_id_flush  = if_id_clr;
    assign pipe.id_ex_write  = id_ex_en;
    assign pipe.id_ex_flush  = id_ex_clr;
    assign pipe.ex_mem_write = ex_mem_en;

    // ------------------------------------------------------------------------
    // State, wait counter, timeout flag and performance counters
    // ------------------------------------------------------------------------
    // NOTE: reset is sampled on the clock edge rather than in the sensitivity
    // list, so every register here is only ever updated at posedge clk.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register sees the pre-edge value of every other register.
        if (!rst_n) begin
            state        <= RUN;
            flush_cnt    <= 4'd0;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            state     <= next_state;
            flush_cnt <= next_flush_cnt;

            // Counts consecutive busy cycles; parks at MEM_TIMEOUT so it
            // cannot wrap during a very long stall.
            if (pipe.dmem_busy) begin
                if (wait_cnt != WAIT_MAX) begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                if (wait_cnt >= WAIT_LAST) begin
                    mem_timeout <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end

            if (!pc_en && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end

            if (branch_accept && (flush_events != CNT_MAX)) begin
                flush_events <= flush_events + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Table-driven bench for hazard_stall_ctrl with FLUSH_CYCLES=2, MEM_TIMEOUT=4
// and CNT_W=3. Each table row is one clock cycle of inputs plus the stage
// controls expected in that cycle and the counter values expected to be
// visible during it (i.e. reflecting all earlier edges). Rows are pushed to a
// scoreboard queue when driven and popped and compared on the falling edge.
// ----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int CNT_W = 3;

    // Control pattern: {pc_write, if_id_write, if_id_flush,
    //                   id_ex_write, id_ex_flush, ex_mem_write}
    localparam logic [5:0] RUNP = 6'b110101;  // everything advances
    localparam logic [5:0] STLP = 6'b000111;  // load-use bubble
    localparam logic [5:0] FLSP = 6'b111111;  // branch flush
    localparam logic [5:0] FRZP = 6'b000000;  // memory freeze
    localparam logic [5:0] RSTP = 6'b001010;  // in reset

    typedef struct {
        string      name;
        logic       rst_n;
        logic       lu;
        logic       br;
        logic       busy;
        logic [5:0] ctl;
        int         stall;
        int         flush;
        logic       to;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if pipe ();
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    logic             mem_timeout;

    hazard_stall_ctrl #(
        .FLUSH_CYCLES (2),
        .MEM_TIMEOUT  (4),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe         (pipe),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events),
        .mem_timeout  (mem_timeout)
    );

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic vec_t mk(input string name, input logic r, input logic lu,
                                input logic br, input logic busy, input logic [5:0] ctl,
                                input int st, input int fe, input logic to);
        vec_t v;
        v.name  = name;
        v.rst_n = r;
        v.lu    = lu;
        v.br    = br;
        v.busy  = busy;
        v.ctl   = ctl;
        v.stall = st;
        v.flush = fe;
        v.to    = to;
        return v;
    endfunction

    function automatic void add(input string name, input logic r, input logic lu,
                                input logic br, input logic busy, input logic [5:0] ctl,
                                input int st, input int fe, input logic to);
        vecs.push_back(mk(name, r, lu, br, busy, ctl, st, fe, to));
    endfunction

    // Drive one cycle of stimulus just after the rising edge and queue the
    // expectation for the checker.
    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        rst_n                = v.rst_n;
        pipe.load_use_hazard = v.lu;
        pipe.branch_taken    = v.br;
        pipe.dmem_busy       = v.busy;
        sb.push_back(v);
    endtask

    // Checker: compares the oldest pending expectation mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            vec_t       e;
            logic [5:0] ctl_now;
            e = sb.pop_front();
            ctl_now = {pipe.pc_write, pipe.if_id_write, pipe.if_id_flush,
                       pipe.id_ex_write, pipe.id_ex_flush, pipe.ex_mem_write};
            check({e.name, "/ctl"},   {26'b0, ctl_now},      {26'b0, e.ctl});
            check({e.name, "/stall"}, 32'(stall_cycles),     32'(e.stall));
            check({e.name, "/flush"}, 32'(flush_events),     32'(e.flush));
            check({e.name, "/tmo"},   {31'b0, mem_timeout},  {31'b0, e.to});
        end
    end

    initial begin
        pipe.load_use_hazard = 1'b0;
        pipe.branch_taken    = 1'b0;
        pipe.dmem_busy       = 1'b0;

        // Load-use: single pulse, then held high for three cycles.
        add("idle_after_rst",      1, 0, 0, 0, RUNP, 0, 0, 0);
        add("lu_pulse",            1, 1, 0, 0, STLP, 0, 0, 0);
        add("lu_pulse_recover",    1, 0, 0, 0, RUNP, 1, 0, 0);
        add("lu_idle",             1, 0, 0, 0, RUNP, 1, 0, 0);
        add("lu_hold1",            1, 1, 0, 0, STLP, 1, 0, 0);
        add("lu_hold2_masked",     1, 1, 0, 0, RUNP, 2, 0, 0);
        add("lu_hold3",            1, 1, 0, 0, STLP, 2, 0, 0);
        add("lu_hold_end",         1, 0, 0, 0, RUNP, 3, 0, 0);
        // Branch with a two-cycle flush; load-use in the 2nd cycle is masked.
        add("br_take",             1, 0, 1, 0, FLSP, 3, 0, 0);
        add("br_flush2_lu_masked", 1, 1, 0, 0, FLSP, 3, 1, 0);
        add("br_done",             1, 0, 0, 0, RUNP, 3, 1, 0);
        // Priority cases.
        add("br_and_lu",           1, 1, 1, 0, FLSP, 3, 1, 0);
        add("br_restart",          1, 0, 1, 0, FLSP, 3, 2, 0);
        add("busy_with_br",        1, 0, 1, 1, FRZP, 3, 3, 0);
        add("br_as_busy_drops",    1, 0, 1, 0, FLSP, 4, 3, 0);
        add("flush_tail",          1, 0, 0, 0, FLSP, 4, 4, 0);
        add("flush_over",          1, 0, 0, 0, RUNP, 4, 4, 0);
        // Reset in the middle of a flush sequence abandons it.
        add("br_before_rst",       1, 0, 1, 0, FLSP, 4, 4, 0);
        add("rst_mid_flush",       0, 1, 1, 1, RSTP, 4, 5, 0);
        add("run_after_rst",       1, 0, 0, 0, RUNP, 0, 0, 0);
        // Timeout: busy 3, idle 1, busy 4; flag visible only after 4th.
        add("busy1",               1, 0, 0, 1, FRZP, 0, 0, 0);
        add("busy2",               1, 0, 0, 1, FRZP, 1, 0, 0);
        add("busy3",               1, 0, 0, 1, FRZP, 2, 0, 0);
        add("busy_gap",            1, 0, 0, 0, RUNP, 3, 0, 0);
        add("busy_a",              1, 0, 0, 1, FRZP, 3, 0, 0);
        add("busy_b",              1, 0, 0, 1, FRZP, 4, 0, 0);
        add("busy_c",              1, 0, 0, 1, FRZP, 5, 0, 0);
        add("busy_d",              1, 0, 0, 1, FRZP, 6, 0, 0);
        add("tmo_set",             1, 0, 0, 0, RUNP, 7, 0, 1);
        add("tmo_sticky",          1, 0, 0, 0, RUNP, 7, 0, 1);
        // Reset clears the flag, then 10 load-use stalls saturate at 7.
        add("rst_clear",           0, 0, 0, 0, RSTP, 7, 0, 1);
        for (int i = 0; i < 10; i++) begin
            add("sat_lu",   1, 1, 0, 0, STLP, (i < 7) ? i : 7, 0, 0);
            add("sat_pass", 1, 0, 0, 0, RUNP, (i + 1 < 7) ? i + 1 : 7, 0, 0);
        end
        add("sat_hold",            1, 0, 0, 0, RUNP, 7, 0, 0);

        // Reset held for three cycles with random requests.
        for (int i = 0; i < 3; i++) begin
            apply(mk("reset_rand", 1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                     RSTP, 0, 0, 1'b0));
        end

        foreach (vecs[i]) begin
            apply(vecs[i]);
        end

        // Let the checker drain, bounded.
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            check("scoreboard_drain", 32'(sb.size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
